// File: rtl/tri_raster_scheduler.sv
// Raster scheduler: walks one triangle's pixel bounding box into the
// coefficient pipeline and tracks which pipeline slots hold real pixels.
module tri_raster_scheduler #(
    parameter int XWIDTH     = 16,
    parameter int YWIDTH     = 16,
    parameter int AINV_WIDTH = 16,
    parameter int HWIDTH     = 10,
    parameter int VWIDTH     = 10,
    parameter int LATENCY    = 6
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic                    tri_valid,
    output logic                    tri_ready,
    input  logic [HWIDTH-1:0]       hmin,
    input  logic [HWIDTH-1:0]       hmax,
    input  logic [VWIDTH-1:0]       vmin,
    input  logic [VWIDTH-1:0]       vmax,
    input  logic [XWIDTH-1:0]       x_start,
    input  logic [XWIDTH-1:0]       x_step,
    input  logic [YWIDTH-1:0]       y_start,
    input  logic [YWIDTH-1:0]       y_step,
    input  logic [3*XWIDTH-1:0]     x_tri_in,
    input  logic [3*YWIDTH-1:0]     y_tri_in,
    input  logic [AINV_WIDTH-1:0]   iarea_in,
    output logic [XWIDTH-1:0]       pipe_x,
    output logic [YWIDTH-1:0]       pipe_y,
    output logic [3*XWIDTH-1:0]     pipe_x_tri,
    output logic [3*YWIDTH-1:0]     pipe_y_tri,
    output logic [AINV_WIDTH-1:0]   pipe_iarea,
    output logic                    pipe_freeze,
    input  logic                    pipe_in_tri,
    output logic                    frag_valid,
    input  logic                    frag_ready,
    output logic [HWIDTH-1:0]       frag_h,
    output logic [VWIDTH-1:0]       frag_v,
    output logic                    tri_done
);

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DRAIN} state_t;

    state_t                  r_state;
    logic                    r_tri_ready;
    logic [HWIDTH-1:0]       r_hmin;
    logic [HWIDTH-1:0]       r_hmax;
    logic [VWIDTH-1:0]       r_vmax;
    logic [XWIDTH-1:0]       r_xstart;
    logic [XWIDTH-1:0]       r_xstep;
    logic [YWIDTH-1:0]       r_ystep;
    logic [HWIDTH-1:0]       r_h;
    logic [VWIDTH-1:0]       r_v;
    logic [XWIDTH-1:0]       r_cx;
    logic [YWIDTH-1:0]       r_cy;
    logic [3*XWIDTH-1:0]     r_xtri;
    logic [3*YWIDTH-1:0]     r_ytri;
    logic [AINV_WIDTH-1:0]   r_iarea;
    logic [LATENCY-1:0]      r_tok;
    logic [HWIDTH-1:0]       r_ph [LATENCY];
    logic [VWIDTH-1:0]       r_pv [LATENCY];

    logic w_frag_valid;
    logic w_freeze;
    logic w_issue;
    logic w_last_col;
    logic w_last;
    logic w_done;
    logic w_accept;

    assign w_frag_valid = r_tok[LATENCY-1] && pipe_in_tri;
    assign w_freeze     = w_frag_valid && !frag_ready;
    assign w_issue      = (r_state == S_SCAN) && !w_freeze;
    assign w_last_col   = (r_h == r_hmax);
    assign w_last       = w_last_col && (r_v == r_vmax);
    assign w_done       = (r_state == S_DRAIN) && (r_tok == '0)
                          && !w_frag_valid;
    assign w_accept     = (r_state == S_IDLE) && r_tri_ready && tri_valid;

    assign tri_ready   = r_tri_ready;
    assign tri_done    = w_done;
    assign frag_valid  = w_frag_valid;
    assign pipe_freeze = w_freeze;
    assign frag_h      = r_ph[LATENCY-1];
    assign frag_v      = r_pv[LATENCY-1];
    assign pipe_x      = r_cx;
    assign pipe_y      = r_cy;
    assign pipe_x_tri  = r_xtri;
    assign pipe_y_tri  = r_ytri;
    assign pipe_iarea  = r_iarea;

    // Control FSM: accept a descriptor, walk the box, wait for drain.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_state     <= S_IDLE;
            r_tri_ready <= 1'b0;
            r_hmin      <= '0;
            r_hmax      <= '0;
            r_vmax      <= '0;
            r_xstart    <= '0;
            r_xstep     <= '0;
            r_ystep     <= '0;
            r_h         <= '0;
            r_v         <= '0;
            r_cx        <= '0;
            r_cy        <= '0;
            r_xtri      <= '0;
            r_ytri      <= '0;
            r_iarea     <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_tri_ready <= 1'b0;
                        r_hmin      <= hmin;
                        r_hmax      <= hmax;
                        r_vmax      <= vmax;
                        r_xstart    <= x_start;
                        r_xstep     <= x_step;
                        r_ystep     <= y_step;
                        r_h         <= hmin;
                        r_v         <= vmin;
                        r_cx        <= x_start;
                        r_cy        <= y_start;
                        r_xtri      <= x_tri_in;
                        r_ytri      <= y_tri_in;
                        r_iarea     <= iarea_in;
                        if ((hmin > hmax) || (vmin > vmax))
                            r_state <= S_DRAIN;
                        else
                            r_state <= S_SCAN;
                    end else begin
                        r_tri_ready <= 1'b1;
                    end
                end
                S_SCAN: begin
                    if (w_issue) begin
                        if (w_last)
                            r_state <= S_DRAIN;
                        if (w_last_col) begin
                            r_h  <= r_hmin;
                            r_cx <= r_xstart;
                            r_v  <= r_v + 1'b1;
                            r_cy <= r_cy + r_ystep;
                        end else begin
                            r_h  <= r_h + 1'b1;
                            r_cx <= r_cx + r_xstep;
                        end
                    end
                end
                S_DRAIN: begin
                    if (w_done) begin
                        r_state     <= S_IDLE;
                        r_tri_ready <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Token and pixel-index shift registers, mirroring the pipeline.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_tok <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                r_ph[i] <= '0;
                r_pv[i] <= '0;
            end
        end else if (!w_freeze) begin
            r_tok   <= {r_tok[LATENCY-2:0], w_issue};
            r_ph[0] <= r_h;
            r_pv[0] <= r_v;
            for (int i = 1; i < LATENCY; i++) begin
                r_ph[i] <= r_ph[i-1];
                r_pv[i] <= r_pv[i-1];
            end
        end
    end

endmodule

// File: tb/tb_tri_raster_scheduler.sv
// Self-checking bench for tri_raster_scheduler: table of box scenarios
// plus reset-abort and back-to-back descriptor sequences.
module tb_tri_raster_scheduler;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic        tri_valid = 1'b0;
    logic        tri_ready;
    logic [9:0]  hmin = '0, hmax = '0, vmin = '0, vmax = '0;
    logic [15:0] x_start = '0, x_step = '0, y_start = '0, y_step = '0;
    logic [47:0] x_tri_in = '0, y_tri_in = '0;
    logic [15:0] iarea_in = '0;
    logic [15:0] pipe_x, pipe_y, pipe_iarea;
    logic [47:0] pipe_x_tri, pipe_y_tri;
    logic        pipe_freeze, pipe_in_tri;
    logic        frag_valid;
    logic        frag_ready = 1'b1;
    logic [9:0]  frag_h, frag_v;
    logic        tri_done;

    tri_raster_scheduler dut (
        .clk_in(clk_in), .rst_in(rst_in),
        .tri_valid(tri_valid), .tri_ready(tri_ready),
        .hmin(hmin), .hmax(hmax), .vmin(vmin), .vmax(vmax),
        .x_start(x_start), .x_step(x_step),
        .y_start(y_start), .y_step(y_step),
        .x_tri_in(x_tri_in), .y_tri_in(y_tri_in), .iarea_in(iarea_in),
        .pipe_x(pipe_x), .pipe_y(pipe_y),
        .pipe_x_tri(pipe_x_tri), .pipe_y_tri(pipe_y_tri),
        .pipe_iarea(pipe_iarea), .pipe_freeze(pipe_freeze),
        .pipe_in_tri(pipe_in_tri),
        .frag_valid(frag_valid), .frag_ready(frag_ready),
        .frag_h(frag_h), .frag_v(frag_v), .tri_done(tri_done)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        int hmin, hmax, vmin, vmax;
        bit rej;
        int rh, rv;
        int stall_idx, stall_len;
        bit rmode;
        int nfr, first_lat, done_lat, nfreeze;
    } vec_t;

    typedef struct {
        logic [9:0]  hmin, hmax, vmin, vmax;
        logic [15:0] xs, xstep, ys, ystep;
        logic [47:0] xt, yt;
        logic [15:0] ia;
    } desc_t;

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    int nfrag = 0, nfreeze = 0, ndone = 0, nfv = 0;
    int first_cyc = -1, done_cyc = -1;
    int stall_idx = 0, stall_left = 0;
    bit rmode = 0;
    bit rej_en = 0;
    logic [7:0] rej_h = '0, rej_v = '0;
    int sb[$];

    logic [15:0] bp_x [6];
    logic [15:0] bp_y [6];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Model of the external coefficient pipeline: 6 stages, freezable.
    always @(posedge clk_in) begin
        cyc <= cyc + 1;
        if (!pipe_freeze) begin
            bp_x[0] <= pipe_x;
            bp_y[0] <= pipe_y;
            for (int i = 1; i < 6; i++) begin
                bp_x[i] <= bp_x[i-1];
                bp_y[i] <= bp_y[i-1];
            end
        end
    end

    assign pipe_in_tri = !(rej_en && bp_x[5][15:8] == rej_h
                                  && bp_y[5][15:8] == rej_v);

    // Downstream ready generator.
    always @(posedge clk_in) begin
        #1;
        if (rmode)
            frag_ready = frag_valid;
        else if (stall_left > 0 && frag_valid && nfrag == stall_idx) begin
            frag_ready = 1'b0;
            stall_left = stall_left - 1;
        end else
            frag_ready = 1'b1;
    end

    // Output monitor and scoreboard consumer.
    always @(negedge clk_in) begin
        if (!rst_in) begin
            if (frag_valid) nfv++;
            if (frag_valid && frag_ready) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL extra_frag: actual=(%0d,%0d) required=none",
                             frag_h, frag_v);
                end else begin
                    int e;
                    e = sb.pop_front();
                    check("frag_h", 32'(frag_h), 32'(e / 1024));
                    check("frag_v", 32'(frag_v), 32'(e % 1024));
                end
                nfrag++;
                if (first_cyc < 0) first_cyc = cyc;
            end
            if (pipe_freeze) nfreeze++;
            if (tri_done) begin
                ndone++;
                done_cyc = cyc;
                check("ready_during_done", 32'(tri_ready), 0);
            end
        end
    end

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    function automatic desc_t mk(input int h0, input int h1,
                                 input int v0, input int v1,
                                 input int xs, input int ys);
        desc_t d;
        d.hmin  = 10'(h0);
        d.hmax  = 10'(h1);
        d.vmin  = 10'(v0);
        d.vmax  = 10'(v1);
        d.xs    = 16'(xs);
        d.xstep = 16'h0100;
        d.ys    = 16'(ys);
        d.ystep = 16'h0100;
        d.xt    = 48'h0003_0002_0001;
        d.yt    = 48'h0006_0005_0004;
        d.ia    = 16'h1234;
        return d;
    endfunction

    task automatic send(input desc_t d, output int acc);
        bit r;
        bit ok;
        hmin = d.hmin;  hmax = d.hmax;
        vmin = d.vmin;  vmax = d.vmax;
        x_start = d.xs; x_step = d.xstep;
        y_start = d.ys; y_step = d.ystep;
        x_tri_in = d.xt; y_tri_in = d.yt; iarea_in = d.ia;
        for (int v = int'(d.vmin); v <= int'(d.vmax); v++)
            for (int h = int'(d.hmin); h <= int'(d.hmax); h++)
                if (!(rej_en && h == int'(rej_h) && v == int'(rej_v)))
                    sb.push_back(h * 1024 + v);
        tri_valid = 1'b1;
        ok = 0;
        acc = -1;
        for (int n = 0; n < 300; n++) begin
            r = tri_ready;
            acc = cyc;
            tick();
            if (r) begin
                ok = 1;
                break;
            end
        end
        tri_valid = 1'b0;
        if (!ok) begin
            n_checks++;
            n_fail++;
            $display("FAIL accept_timeout: actual=no_accept required=accept");
        end
    endtask

    task automatic wait_done(input int n0);
        for (int n = 0; n < 300; n++) begin
            if (ndone > n0) break;
            tick();
        end
        if (ndone <= n0) begin
            n_checks++;
            n_fail++;
            $display("FAIL done_timeout: actual=no_tri_done required=tri_done");
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: actual=hung required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t  tbl[5];
        vec_t  t;
        desc_t d;
        int    acc, acc2, n0f, n0z, n0d, n0v, act_first;

        tbl[0] = '{0,1,0,1, 0,0,0, 0,0, 0, 4, 7,11, 0};
        tbl[1] = '{0,1,0,1, 0,0,0, 1,3, 0, 4, 7,14, 3};
        tbl[2] = '{0,1,0,1, 1,1,0, 0,0, 1, 3, 7,11, 0};
        tbl[3] = '{5,4,0,1, 0,0,0, 0,0, 0, 0,-1, 1, 0};
        tbl[4] = '{0,2,3,4, 1,2,3, 2,2, 0, 5, 7,15, 2};

        for (int i = 0; i < 6; i++) begin
            bp_x[i] = '0;
            bp_y[i] = '0;
        end
        repeat (3) tick();
        check("rst_tri_ready", 32'(tri_ready), 0);
        check("rst_frag_valid", 32'(frag_valid), 0);
        check("rst_tri_done", 32'(tri_done), 0);
        check("rst_freeze", 32'(pipe_freeze), 0);
        check("rst_pipe_x", 32'(pipe_x), 0);
        rst_in = 1'b0;
        check("rel_tri_ready0", 32'(tri_ready), 0);
        tick();
        check("rel_tri_ready1", 32'(tri_ready), 1);

        for (int i = 0; i < 5; i++) begin
            t = tbl[i];
            rej_en = t.rej;
            rej_h = 8'(t.rh);
            rej_v = 8'(t.rv);
            stall_idx = nfrag + t.stall_idx;
            stall_left = t.stall_len;
            rmode = t.rmode;
            n0f = nfrag;
            n0z = nfreeze;
            n0d = ndone;
            first_cyc = -1;
            d = mk(t.hmin, t.hmax, t.vmin, t.vmax,
                   t.hmin * 256, t.vmin * 256);
            send(d, acc);
            wait_done(n0d);
            act_first = (first_cyc < 0) ? -1 : first_cyc - acc;
            check($sformatf("v%0d_nfrag", i), 32'(nfrag - n0f), 32'(t.nfr));
            check($sformatf("v%0d_first_lat", i), 32'(act_first),
                  32'(t.first_lat));
            check($sformatf("v%0d_done_lat", i), 32'(done_cyc - acc),
                  32'(t.done_lat));
            check($sformatf("v%0d_freeze", i), 32'(nfreeze - n0z),
                  32'(t.nfreeze));
            rmode = 0;
            rej_en = 0;
            tick();
            check($sformatf("v%0d_ready_back", i), 32'(tri_ready), 1);
            check($sformatf("v%0d_sb_empty", i), 32'(sb.size()), 0);
        end

        // Reset in the middle of a 4x4 scan after 7 issues.
        d = mk(0, 3, 0, 3, 0, 0);
        send(d, acc);
        repeat (7) tick();
        check("pre_rst_frag_valid", 32'(frag_valid), 1);
        rst_in = 1'b1;
        #1;
        check("mid_rst_frag_valid", 32'(frag_valid), 0);
        check("mid_rst_tri_done", 32'(tri_done), 0);
        check("mid_rst_freeze", 32'(pipe_freeze), 0);
        check("mid_rst_tri_ready", 32'(tri_ready), 0);
        check("mid_rst_pipe_x", 32'(pipe_x), 0);
        check("mid_rst_pipe_y", 32'(pipe_y), 0);
        sb.delete();
        n0d = ndone;
        n0v = nfv;
        repeat (2) tick();
        rst_in = 1'b0;
        check("post_rst_ready0", 32'(tri_ready), 0);
        tick();
        check("post_rst_ready1", 32'(tri_ready), 1);
        repeat (20) tick();
        check("post_rst_no_fv", 32'(nfv - n0v), 0);
        check("post_rst_no_done", 32'(ndone - n0d), 0);
        n0f = nfrag;
        n0d = ndone;
        d = mk(0, 1, 0, 1, 0, 0);
        send(d, acc);
        wait_done(n0d);
        check("post_rst_nfrag", 32'(nfrag - n0f), 4);
        check("post_rst_done_lat", 32'(done_cyc - acc), 11);

        // Back-to-back descriptors: the second waits for the first.
        repeat (2) tick();
        n0f = nfrag;
        n0d = ndone;
        d = mk(0, 1, 0, 0, 0, 0);
        send(d, acc);
        d = mk(0, 1, 0, 0, 16'h0800, 0);
        d.ia = 16'h5a5a;
        d.xt = 48'h0009_0008_0007;
        send(d, acc2);
        check("b2b_accept_gap", 32'(acc2 - acc), 10);
        check("b2b_after_done", 32'(acc2), 32'(done_cyc + 1));
        check("b2b_pipe_x0", 32'(pipe_x), 32'h0800);
        check("b2b_iarea", 32'(pipe_iarea), 32'h5a5a);
        check("b2b_x_tri", 32'(pipe_x_tri[31:0]), 32'h0008_0007);
        tick();
        check("b2b_pipe_x1", 32'(pipe_x), 32'h0900);
        wait_done(n0d + 1);
        check("b2b_nfrag", 32'(nfrag - n0f), 4);
        check("b2b_sb_empty", 32'(sb.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tri_raster_scheduler.md
Name: tri_raster_scheduler

Overview:
- Sequences one triangle at a time through the barycentric coefficient pipeline.
- Walks the triangle's pixel bounding box in raster order and presents sample coordinates plus held triangle data to the pipeline.
- Tracks which pipeline slots hold real pixels, since the pipeline carries no valid tokens.
- Emits fragments downstream with a valid/ready handshake and turns downstream stall into the pipeline's freeze.

Parameters:
- XWIDTH, 16, fixed-point sample x width (signed).
- YWIDTH, 16, fixed-point sample y width (signed).
- AINV_WIDTH, 16, inverse-area width, passed through.
- HWIDTH, 10, pixel column index width (unsigned).
- VWIDTH, 10, pixel row index width (unsigned).
- LATENCY, 6, coefficient pipeline latency in cycles.

Ports:
- clk_in  in  1  clock.
- rst_in  in  1  asynchronous active-high reset.
- tri_valid  in  1  triangle descriptor valid.
- tri_ready  out  1  accepting a descriptor (IDLE only).
- hmin, hmax  in  HWIDTH each  inclusive column bounds.
- vmin, vmax  in  VWIDTH each  inclusive row bounds.
- x_start, x_step  in  XWIDTH each  sample x at hmin; per-column increment.
- y_start, y_step  in  YWIDTH each  sample y at vmin; per-row increment.
- x_tri_in, y_tri_in  in  3xXWIDTH, 3xYWIDTH  vertices.
- iarea_in  in  AINV_WIDTH  inverse area.
- pipe_x, pipe_y  out  XWIDTH, YWIDTH  sample coordinates to the pipeline.
- pipe_x_tri, pipe_y_tri, pipe_iarea  out  as inputs  latched triangle data.
- pipe_freeze  out  1  pipeline freeze.
- pipe_in_tri  in  1  pipeline valid_out (in-triangle flag).
- frag_valid  out  1  fragment available.
- frag_ready  in  1  downstream accepts.
- frag_h, frag_v  out  HWIDTH, VWIDTH  pixel indices of the fragment.
- tri_done  out  1  one-cycle pulse when the last fragment has drained.

Behaviour:
- Reset (async, rst_in=1):
  - state=IDLE; token shift register tok[LATENCY-1:0]=0.
  - frag_valid=0, tri_done=0, pipe_freeze=0, tri_ready=0.
  - Counters and pipe_* data are zeroed.
  - tri_ready rises the first cycle after rst_in deasserts.
- States:
  - IDLE: tri_ready=1. On tri_valid, latch all descriptor fields, set h=hmin, v=vmin, cx=x_start, cy=y_start. Go to DRAIN if hmin>hmax or vmin>vmax, else SCAN.
  - SCAN:
    - issue = !pipe_freeze.
    - On each issue: advance h, cx+=x_step.
    - If h==hmax: h=hmin, cx=x_start, v++, cy+=y_step.
    - Issuing the pixel with h==hmax && v==vmax moves to DRAIN.
  - DRAIN: no issues. When tok==0 and frag_valid==0, pulse tri_done for one cycle and go to IDLE.
- pipe_x=cx and pipe_y=cy come from registers; pipe_x_tri, pipe_y_tri and pipe_iarea hold the latched values until the next accept.
- Token pipeline:
  - When !pipe_freeze: tok shifts, and tok[0]<=issue.
  - Pixel (h,v) shift registers run in parallel.
  - When pipe_freeze: everything holds.
  - A pixel presented in cycle c has its coefficients at the pipeline output in cycle c+LATENCY.
- Output:
  - frag_valid = tok[LATENCY-1] && pipe_in_tri (combinational).
  - frag_h and frag_v come from the last stage.
  - Tokens with pipe_in_tri=0 are discarded silently.
- pipe_freeze = frag_valid && !frag_ready (combinational); frag_valid and fragment data hold while frozen.
- Arithmetic:
  - cx and cy wrap modulo 2^XWIDTH and 2^YWIDTH.
  - The bounding box must lie within representable range; out-of-range bounding boxes are the producer's fault.
- Simultaneous events:
  - A descriptor is never accepted outside IDLE.
  - tri_done and tri_ready are never high in the same cycle.
- Reset mid-scan aborts the triangle: no tri_done, all tokens dropped, no frag_valid afterwards.

Test Plan:
- Box h 0..1, v 0..1, all pipe_in_tri=1, frag_ready=1:
  - Fragments (0,0),(1,0),(0,1),(1,1) appear on consecutive cycles.
  - First fragment is 6 cycles after the first issue.
  - tri_done follows the last fragment by one cycle.
- Same box with frag_ready=0 for 3 cycles on the second fragment:
  - pipe_freeze=1 for exactly those cycles.
  - frag (1,0) holds; no fragment is lost or duplicated.
  - Total completion time grows by 3.
- pipe_in_tri=0 for pixel (1,0):
  - Only 3 fragments appear.
  - pipe_freeze stays 0 even with frag_ready=0 during that slot.
- hmin=5, hmax=4: accepted; no fragments; tri_done 1 cycle after accept; tri_ready back the next cycle.
- Box 0..3 x 0..3, rst_in pulsed after 7 issues:
  - All outputs go to reset values immediately.
  - No frag_valid or tri_done afterwards.
  - A new triangle is accepted cleanly.
- Two back-to-back descriptors:
  - The second is held (tri_ready=0) until the first's tri_done.
  - The second then scans with its own x_start=0x0800, x_step=0x0100, giving pipe_x sequence 0x0800, 0x0900.
